// File: rtl/smi_mem_test_pkg.sv
// Shared types and widths for the memory burst test sequencer.
package smi_mem_test_pkg;

  localparam int unsigned ADDR_W          = 64;
  localparam int unsigned DATA_W          = 64;
  localparam int unsigned LEN_W           = 32;
  localparam int unsigned OPTS_W          = 8;
  localparam int unsigned COUNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    Idle,
    WriteParams,
    WriteDone,
    ReadParams,
    ReadDone,
    NextBurst,
    Report
  } seqState_t;

endpackage

// File: rtl/smi_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module smi_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/smi_mem_lib_burst_test_sequencer.sv
// Sequences write-then-read test bursts over an address range and reports
// the accumulated failure count once all bursts have completed.
module smi_mem_lib_burst_test_sequencer
  import smi_mem_test_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               srst,

  input  logic               startValid,
  input  logic [ADDR_W-1:0]  startBaseAddr,
  input  logic [ADDR_W-1:0]  startAddrStride,
  input  logic [LEN_W-1:0]   startBurstLen,
  input  logic [OPTS_W-1:0]  startBurstOpts,
  input  logic [COUNT_W-1:0] startBurstCount,
  input  logic [DATA_W-1:0]  startDataInit,
  input  logic [DATA_W-1:0]  startDataIncr,
  output logic               startStop,

  output logic               writeTestParamsValid,
  output logic [ADDR_W-1:0]  writeTestParamBurstAddr,
  output logic [LEN_W-1:0]   writeTestParamBurstLen,
  output logic [OPTS_W-1:0]  writeTestParamBurstOpts,
  output logic [DATA_W-1:0]  writeTestParamDataInit,
  output logic [DATA_W-1:0]  writeTestParamDataIncr,
  input  logic               writeTestParamsStop,

  input  logic               writeTestDoneValid,
  input  logic               writeTestDoneStatusOk,
  output logic               writeTestDoneStop,

  output logic               readTestParamsValid,
  output logic [ADDR_W-1:0]  readTestParamBurstAddr,
  output logic [LEN_W-1:0]   readTestParamBurstLen,
  output logic [OPTS_W-1:0]  readTestParamBurstOpts,
  output logic [DATA_W-1:0]  readTestParamDataInit,
  output logic [DATA_W-1:0]  readTestParamDataIncr,
  input  logic               readTestParamsStop,

  input  logic               readTestDoneValid,
  input  logic               readTestDoneStatusOk,
  output logic               readTestDoneStop,

  output logic               resultValid,
  output logic               resultStatusOk,
  output logic [COUNT_W-1:0] resultFailCount,
  input  logic               resultStop
);

  seqState_t state;
  seqState_t stateNext;

  logic [ADDR_W-1:0]  addrStride;
  logic [LEN_W-1:0]   burstLen;
  logic [OPTS_W-1:0]  burstOpts;
  logic [COUNT_W-1:0] burstCount;
  logic [DATA_W-1:0]  dataIncr;
  logic [COUNT_W-1:0] burstIdx;
  logic [COUNT_W-1:0] burstIdxInc;
  logic [ADDR_W-1:0]  curAddr;
  logic [DATA_W-1:0]  curInit;
  logic [COUNT_W-1:0] failCount;

  logic capture;
  logic advance;
  logic failClr;
  logic failInc;

  assign burstIdxInc = burstIdx + COUNT_W'(1);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state <= Idle;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext            = state;
    startStop            = 1'b1;
    writeTestParamsValid = 1'b0;
    readTestParamsValid  = 1'b0;
    writeTestDoneStop    = 1'b1;
    readTestDoneStop     = 1'b1;
    resultValid          = 1'b0;
    resultStatusOk       = 1'b0;
    capture              = 1'b0;
    advance              = 1'b0;
    failClr              = 1'b0;
    failInc              = 1'b0;
    case (state)
      Idle: begin
        startStop = 1'b0;
        if (startValid) begin
          capture   = 1'b1;
          failClr   = 1'b1;
          stateNext = (startBurstCount == '0) ? Report : WriteParams;
        end
      end
      WriteParams: begin
        writeTestParamsValid = 1'b1;
        if (!writeTestParamsStop) begin
          stateNext = WriteDone;
        end
      end
      WriteDone: begin
        writeTestDoneStop = 1'b0;
        if (writeTestDoneValid) begin
          failInc   = ~writeTestDoneStatusOk;
          stateNext = ReadParams;
        end
      end
      ReadParams: begin
        readTestParamsValid = 1'b1;
        if (!readTestParamsStop) begin
          stateNext = ReadDone;
        end
      end
      ReadDone: begin
        readTestDoneStop = 1'b0;
        if (readTestDoneValid) begin
          failInc   = ~readTestDoneStatusOk;
          stateNext = NextBurst;
        end
      end
      NextBurst: begin
        advance   = 1'b1;
        stateNext = (burstIdxInc == burstCount) ? Report : WriteParams;
      end
      Report: begin
        resultValid    = 1'b1;
        resultStatusOk = (failCount == '0);
        if (!resultStop) begin
          stateNext = Idle;
        end
      end
      default: stateNext = Idle;
    endcase
  end

  // Datapath only matters once a start has been captured, so it has no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      addrStride <= startAddrStride;
      burstLen   <= startBurstLen;
      burstOpts  <= startBurstOpts;
      burstCount <= startBurstCount;
      dataIncr   <= startDataIncr;
      burstIdx   <= '0;
      curAddr    <= startBaseAddr;
      curInit    <= startDataInit;
    end else if (advance) begin
      burstIdx   <= burstIdxInc;
      curAddr    <= curAddr + addrStride;
      curInit    <= curInit + DATA_W'(1);
    end
  end

  smi_sat_counter #(
    .WIDTH (COUNT_W)
  ) uFailCount (
    .clk   (clk),
    .srst  (srst),
    .clr   (failClr),
    .inc   (failInc),
    .count (failCount)
  );

  assign resultFailCount = failCount;

  assign writeTestParamBurstAddr = curAddr;
  assign writeTestParamBurstLen  = burstLen;
  assign writeTestParamBurstOpts = burstOpts;
  assign writeTestParamDataInit  = curInit;
  assign writeTestParamDataIncr  = dataIncr;

  assign readTestParamBurstAddr  = curAddr;
  assign readTestParamBurstLen   = burstLen;
  assign readTestParamBurstOpts  = burstOpts;
  assign readTestParamDataInit   = curInit;
  assign readTestParamDataIncr   = dataIncr;

endmodule

// File: tb/tb_smi_mem_lib_burst_test_sequencer.sv
// Scoreboard bench: expected params/results are queued at start and popped as
// the sequencer hands them over to the modelled write, read and result peers.
module tb_smi_mem_lib_burst_test_sequencer;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] len;
    logic [7:0]  opts;
    logic [63:0] init;
    logic [63:0] incr;
  } params_t;

  typedef struct {
    logic          ok;
    logic [CW-1:0] fails;
    int            lat;
  } result_t;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          startValid = 1'b0;
  logic [63:0]   startBaseAddr = '0;
  logic [63:0]   startAddrStride = '0;
  logic [31:0]   startBurstLen = '0;
  logic [7:0]    startBurstOpts = '0;
  logic [CW-1:0] startBurstCount = '0;
  logic [63:0]   startDataInit = '0;
  logic [63:0]   startDataIncr = '0;
  logic          startStop;
  logic          writeTestParamsValid;
  logic [63:0]   writeTestParamBurstAddr;
  logic [31:0]   writeTestParamBurstLen;
  logic [7:0]    writeTestParamBurstOpts;
  logic [63:0]   writeTestParamDataInit;
  logic [63:0]   writeTestParamDataIncr;
  logic          writeTestParamsStop = 1'b0;
  logic          writeTestDoneValid = 1'b0;
  logic          writeTestDoneStatusOk = 1'b1;
  logic          writeTestDoneStop;
  logic          readTestParamsValid;
  logic [63:0]   readTestParamBurstAddr;
  logic [31:0]   readTestParamBurstLen;
  logic [7:0]    readTestParamBurstOpts;
  logic [63:0]   readTestParamDataInit;
  logic [63:0]   readTestParamDataIncr;
  logic          readTestParamsStop = 1'b0;
  logic          readTestDoneValid = 1'b0;
  logic          readTestDoneStatusOk = 1'b1;
  logic          readTestDoneStop;
  logic          resultValid;
  logic          resultStatusOk;
  logic [CW-1:0] resultFailCount;
  logic          resultStop = 1'b0;

  smi_mem_lib_burst_test_sequencer #(
    .COUNT_W (CW)
  ) dut (
    .clk                     (clk),
    .srst                    (srst),
    .startValid              (startValid),
    .startBaseAddr           (startBaseAddr),
    .startAddrStride         (startAddrStride),
    .startBurstLen           (startBurstLen),
    .startBurstOpts          (startBurstOpts),
    .startBurstCount         (startBurstCount),
    .startDataInit           (startDataInit),
    .startDataIncr           (startDataIncr),
    .startStop               (startStop),
    .writeTestParamsValid    (writeTestParamsValid),
    .writeTestParamBurstAddr (writeTestParamBurstAddr),
    .writeTestParamBurstLen  (writeTestParamBurstLen),
    .writeTestParamBurstOpts (writeTestParamBurstOpts),
    .writeTestParamDataInit  (writeTestParamDataInit),
    .writeTestParamDataIncr  (writeTestParamDataIncr),
    .writeTestParamsStop     (writeTestParamsStop),
    .writeTestDoneValid      (writeTestDoneValid),
    .writeTestDoneStatusOk   (writeTestDoneStatusOk),
    .writeTestDoneStop       (writeTestDoneStop),
    .readTestParamsValid     (readTestParamsValid),
    .readTestParamBurstAddr  (readTestParamBurstAddr),
    .readTestParamBurstLen   (readTestParamBurstLen),
    .readTestParamBurstOpts  (readTestParamBurstOpts),
    .readTestParamDataInit   (readTestParamDataInit),
    .readTestParamDataIncr   (readTestParamDataIncr),
    .readTestParamsStop      (readTestParamsStop),
    .readTestDoneValid       (readTestDoneValid),
    .readTestDoneStatusOk    (readTestDoneStatusOk),
    .readTestDoneStop        (readTestDoneStop),
    .resultValid             (resultValid),
    .resultStatusOk          (resultStatusOk),
    .resultFailCount         (resultFailCount),
    .resultStop              (resultStop)
  );

  always #5 clk = ~clk;

  params_t wrQ[$];
  params_t rdQ[$];
  result_t resQ[$];

  int checks = 0;
  int errors = 0;

  int cyc = 0, startCyc = 0;
  int wrStall = 0, rdStall = 0, resStall = 0;
  int wrBurst = 0, rdBurst = 0, rdXfer = 0;
  logic [15:0] wrFail = '0, rdFail = '0;
  bit wrPend = 0, rdPend = 0, wrTaken = 0, rdTaken = 0;
  bit wrHeld = 0, rdHeld = 0, resHeld = 0, resFirst = 0;
  bit busy = 0, resDone = 0;
  params_t wrHeldP, rdHeldP, curW, curR, e;
  logic heldOk;
  logic [CW-1:0] heldFails;
  result_t r;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peer models: param sinks with optional stall, one-cycle done responders, result sink.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (srst) begin
        writeTestDoneValid = 1'b0;
        readTestDoneValid  = 1'b0;
        wrPend = 0; rdPend = 0; wrTaken = 0; rdTaken = 0;
        wrHeld = 0; rdHeld = 0; resHeld = 0; resFirst = 0;
      end else begin
        if (writeTestParamsValid || readTestParamsValid)
          checkVal("paramValidExclusive", 64'(writeTestParamsValid & readTestParamsValid), 64'd0);

        if (wrTaken) writeTestDoneValid = 1'b0;
        if (wrPend) begin
          writeTestDoneValid    = 1'b1;
          writeTestDoneStatusOk = ~wrFail[wrBurst[3:0]];
          wrBurst++;
          wrPend = 0;
        end
        wrTaken = writeTestDoneValid && !writeTestDoneStop;

        if (rdTaken) readTestDoneValid = 1'b0;
        if (rdPend) begin
          readTestDoneValid    = 1'b1;
          readTestDoneStatusOk = ~rdFail[rdBurst[3:0]];
          rdBurst++;
          rdPend = 0;
        end
        rdTaken = readTestDoneValid && !readTestDoneStop;

        writeTestParamsStop = (wrStall > 0);
        if (writeTestParamsValid) begin
          curW = '{writeTestParamBurstAddr, writeTestParamBurstLen, writeTestParamBurstOpts,
                   writeTestParamDataInit, writeTestParamDataIncr};
          if (wrHeld) begin
            checkVal("wrHoldAddr", curW.addr, wrHeldP.addr);
            checkVal("wrHoldInit", curW.init, wrHeldP.init);
          end
          if (writeTestParamsStop) begin
            wrHeld = 1; wrHeldP = curW; wrStall--;
          end else begin
            wrHeld = 0;
            if (wrQ.size() == 0) checkVal("wrUnexpected", 64'd1, 64'd0);
            else begin
              e = wrQ.pop_front();
              checkVal("wrAddr", curW.addr, e.addr);
              checkVal("wrLen",  64'(curW.len), 64'(e.len));
              checkVal("wrOpts", 64'(curW.opts), 64'(e.opts));
              checkVal("wrInit", curW.init, e.init);
              checkVal("wrIncr", curW.incr, e.incr);
            end
            wrPend = 1;
          end
        end

        readTestParamsStop = (rdStall > 0);
        if (readTestParamsValid) begin
          curR = '{readTestParamBurstAddr, readTestParamBurstLen, readTestParamBurstOpts,
                   readTestParamDataInit, readTestParamDataIncr};
          if (rdHeld) begin
            checkVal("rdHoldAddr", curR.addr, rdHeldP.addr);
            checkVal("rdHoldInit", curR.init, rdHeldP.init);
          end
          if (readTestParamsStop) begin
            rdHeld = 1; rdHeldP = curR; rdStall--;
          end else begin
            rdHeld = 0;
            if (rdQ.size() == 0) checkVal("rdUnexpected", 64'd1, 64'd0);
            else begin
              e = rdQ.pop_front();
              checkVal("rdAddr", curR.addr, e.addr);
              checkVal("rdLen",  64'(curR.len), 64'(e.len));
              checkVal("rdOpts", 64'(curR.opts), 64'(e.opts));
              checkVal("rdInit", curR.init, e.init);
              checkVal("rdIncr", curR.incr, e.incr);
            end
            rdXfer++;
            rdPend = 1;
          end
        end

        resultStop = (resStall > 0);
        if (resultValid) begin
          if (!resFirst) begin
            resFirst = 1;
            if (resQ.size() > 0 && resQ[0].lat >= 0)
              checkVal("resLatency", 64'(cyc - startCyc), 64'(resQ[0].lat));
          end
          if (resHeld) begin
            checkVal("resHoldOk", 64'(resultStatusOk), 64'(heldOk));
            checkVal("resHoldFails", 64'(resultFailCount), 64'(heldFails));
          end
          if (resultStop) begin
            resHeld = 1; heldOk = resultStatusOk; heldFails = resultFailCount; resStall--;
          end else begin
            resHeld = 0; resFirst = 0;
            if (resQ.size() == 0) checkVal("resUnexpected", 64'd1, 64'd0);
            else begin
              r = resQ.pop_front();
              checkVal("resOk", 64'(resultStatusOk), 64'(r.ok));
              checkVal("resFails", 64'(resultFailCount), 64'(r.fails));
            end
            busy = 0;
            resDone = 1;
          end
        end
        if (busy) checkVal("startStopBusy", 64'(startStop), 64'd1);
      end
    end
  end

  task automatic startDrive(input logic [63:0] base, input logic [63:0] stride,
                            input logic [31:0] len, input logic [7:0] opts, input int count,
                            input logic [63:0] init, input logic [63:0] incr,
                            input logic [15:0] wf, input logic [15:0] rf, input bit checkLat);
    int nf;
    logic [63:0] a, d;
    result_t rr;
    wrFail = wf; rdFail = rf; wrBurst = 0; rdBurst = 0; rdXfer = 0;
    nf = 0; a = base; d = init;
    for (int i = 0; i < count; i++) begin
      wrQ.push_back('{a, len, opts, d, incr});
      rdQ.push_back('{a, len, opts, d, incr});
      nf = nf + int'(wf[i]) + int'(rf[i]);
      a = a + stride;
      d = d + 64'd1;
    end
    rr.ok    = (nf == 0);
    rr.fails = (nf > 15) ? 4'hF : CW'(nf);
    rr.lat   = checkLat ? (5 * count + 1) : -1;
    resQ.push_back(rr);
    @(negedge clk);
    startValid = 1'b1;
    startBaseAddr = base; startAddrStride = stride; startBurstLen = len;
    startBurstOpts = opts; startBurstCount = CW'(count);
    startDataInit = init; startDataIncr = incr;
    for (int t = 0; t < 50 && startStop; t++) @(negedge clk);
    if (startStop) checkVal("startAccept", 64'(startStop), 64'd0);
    @(posedge clk);
    startCyc = cyc;
    #1;
    busy = 1; resDone = 0;
    startValid = 1'b0;
  endtask

  task automatic waitResult();
    for (int t = 0; t < 2000 && !resDone; t++) @(negedge clk);
    #1;
    checkVal("resDone", 64'(resDone), 64'd1);
    checkVal("wrQEmpty", 64'(wrQ.size()), 64'd0);
    checkVal("rdQEmpty", 64'(rdQ.size()), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "StartStop"}, 64'(startStop), 64'd0);
    checkVal({tag, "WrValid"}, 64'(writeTestParamsValid), 64'd0);
    checkVal({tag, "RdValid"}, 64'(readTestParamsValid), 64'd0);
    checkVal({tag, "WrDoneStop"}, 64'(writeTestDoneStop), 64'd1);
    checkVal({tag, "RdDoneStop"}, 64'(readTestDoneStop), 64'd1);
    checkVal({tag, "ResValid"}, 64'(resultValid), 64'd0);
    checkVal({tag, "ResOk"}, 64'(resultStatusOk), 64'd0);
    checkVal({tag, "ResFails"}, 64'(resultFailCount), 64'd0);
  endtask

  initial begin
    #1;
    checkResetOutputs("rst0");
    @(posedge clk); @(posedge clk);
    #2 srst = 1'b0;

    startDrive(64'h1000, 64'h200, 32'd16, 8'h00, 3, 64'h10, 64'd1, 16'h0, 16'h0, 1);
    waitResult();

    startDrive(64'h5000, 64'h40, 32'd8, 8'h01, 0, 64'h0, 64'd1, 16'h0, 16'h0, 1);
    waitResult();

    startDrive(64'h2000, 64'h100, 32'd4, 8'h3C, 4, 64'h77, 64'd2, 16'h0008, 16'h000A, 1);
    waitResult();

    wrStall = 10; resStall = 5;
    startDrive(64'h8000, 64'h80, 32'd32, 8'h11, 2, 64'h100, 64'd3, 16'h0, 16'h0, 0);
    waitResult();

    startDrive(64'hFFFF_FFFF_FFFF_FF00, 64'h100, 32'd0, 8'hA5, 2, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hDEAD, 16'h0, 16'h0, 1);
    waitResult();

    // Abort in ReadDone of burst 2: reset asserted between clock edges.
    startDrive(64'h3000, 64'h10, 32'd2, 8'h00, 4, 64'h0, 64'd1, 16'h0003, 16'h0, 0);
    for (int t = 0; t < 200 && rdXfer < 3; t++) @(posedge clk);
    #2;
    checkVal("preRstFails", 64'(resultFailCount), 64'd2);
    srst = 1'b1;
    #1;
    checkResetOutputs("rstMid");
    busy = 0;
    wrQ.delete(); rdQ.delete(); resQ.delete();
    @(posedge clk); @(posedge clk);
    #2 srst = 1'b0;

    startDrive(64'h3000, 64'h10, 32'd2, 8'h00, 2, 64'h0, 64'd1, 16'h0, 16'h0, 1);
    waitResult();

    startDrive(64'h0, 64'h8, 32'd1, 8'h00, 15, 64'h0, 64'd1, 16'h7FFF, 16'h7FFF, 1);
    waitResult();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/smi_mem_lib_burst_test_sequencer.md
SMI_MEM_LIB_BURST_TEST_SEQUENCER -- requirements
Module: smi_mem_lib_burst_test_sequencer

Interface
REQ-001 SHALL have parameters: COUNT_W, default 16, burst-count and fail-count width; none other.
REQ-002 SHALL have ports: clk  in  1  single clock; all flops on rising edge.
REQ-003 SHALL have ports: srst  in  1  asynchronous active-high reset.
REQ-004 SHALL have ports: startValid in 1; startBaseAddr in 64; startAddrStride in 64; startBurstLen in 32; startBurstOpts in 8; startBurstCount in COUNT_W; startDataInit in 64; startDataIncr in 64; startStop out 1.
REQ-005 SHALL have ports: writeTestParamsValid out 1; writeTestParamBurstAddr out 64; writeTestParamBurstLen out 32; writeTestParamBurstOpts out 8; writeTestParamDataInit out 64; writeTestParamDataIncr out 64; writeTestParamsStop in 1.
REQ-006 SHALL have ports: writeTestDoneValid in 1; writeTestDoneStatusOk in 1; writeTestDoneStop out 1.
REQ-007 SHALL have ports: readTestParamsValid, readTestParamBurstAddr/Len/Opts/DataInit/DataIncr, readTestParamsStop; readTestDoneValid, readTestDoneStatusOk, readTestDoneStop; widths and directions as REQ-005/006.
REQ-008 SHALL have ports: resultValid out 1; resultStatusOk out 1; resultFailCount out COUNT_W; resultStop in 1.

Function
REQ-009 All handshakes SHALL be valid/stop: transfer occurs in a cycle with valid=1 and stop=0; valid, once raised, SHALL stay high with stable payload until transfer.
REQ-010 States SHALL be Idle, WriteParams, WriteDone, ReadParams, ReadDone, NextBurst, Report.
REQ-011 Idle: startStop=0; on startValid, capture all start fields, set burstIdx=0, failCount=0, curAddr=startBaseAddr, curInit=startDataInit; go WriteParams, or Report if startBurstCount==0.
REQ-012 startStop SHALL be 1 in every state except Idle.
REQ-013 WriteParams: writeTestParamsValid=1 with addr=curAddr, len/opts/incr as captured, init=curInit; on transfer go WriteDone.
REQ-014 WriteDone: writeTestDoneStop=0; on writeTestDoneValid, increment failCount if writeTestDoneStatusOk=0, go ReadParams; writeTestDoneStop=1 in all other states.
REQ-015 ReadParams/ReadDone SHALL mirror REQ-013/014 on the read port, ReadDone exiting to NextBurst.
REQ-016 NextBurst (one cycle): burstIdx+=1, curAddr+=startAddrStride (64-bit, wraps modulo 2^64), curInit+=1 (wraps); go Report if new burstIdx==startBurstCount, else WriteParams.
REQ-017 failCount SHALL saturate at all-ones; never wraps.
REQ-018 Report: resultValid=1, resultStatusOk=(failCount==0), resultFailCount=failCount; on transfer go Idle.
REQ-019 Write and read param valids SHALL never be high simultaneously; at most one burst is outstanding.
REQ-020 startBurstLen=0 SHALL be forwarded unchanged; no special handling.
REQ-021 Done pulses arriving outside the matching Done state SHALL be held off by stop=1, not dropped.
REQ-022 Minimum latency from start transfer to resultValid with zero-stall peers and one-cycle done response: 5 cycles per burst + 1.

Reset
REQ-023 srst assertion SHALL immediately force state Idle; outputs: startStop=0, all param valids 0, both done stops 1, resultValid 0, resultStatusOk 0, resultFailCount 0.
REQ-024 Reset mid-burst SHALL abandon the burst with no result; datapath registers (captured fields, curAddr, curInit) need no reset.

Structure
REQ-025 Package smi_mem_test_pkg SHALL hold the state enum, 64/32/8 width constants, and COUNT_W default.
REQ-026 One sub-module smi_sat_counter (width-parameterised saturating increment with clear) SHALL implement failCount; all else inline.

Verification
REQ-027 Base 0x1000, stride 0x200, len 16, count 3, init 0x10, incr 1, all ok -> write/read addrs 0x1000,0x1200,0x1400; inits 0x10,0x11,0x12; result ok=1, failCount=0.
REQ-028 count 0 -> no param handshakes; resultValid 1 cycle after start transfer, ok=1, failCount=0.
REQ-029 count 4, read status fails on bursts 1 and 3, write status fails on burst 3 -> ok=0, failCount=3.
REQ-030 writeTestParamsStop=1 for 10 cycles, resultStop=1 for 5 cycles -> valid and payload held stable, no duplicate transfers, startStop stays 1.
REQ-031 srst asserted during ReadDone of burst 2 of 4 -> outputs match REQ-023 with no clock edge; new start after release runs from burst 0.
REQ-032 COUNT_W=4, count 15 with every done failing -> failCount saturates at 0xF, ok=0.
